// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the transmit state type for the GMII framer and receive-side checker.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    DROP,
    IFG
  } tx_state_t;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB_20E3;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32 (LSB of the byte first).
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_in[i]) c = (c >> 1) ^ ETH_CRC_POLY;
      else                   c = c >> 1;
    end
  end

  assign crc_out = c;

endmodule

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, optional zero padding (ETH_TX_PAD_EN), FCS and IFG.
module eth_gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int IFG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic       logic_clk,
  input  logic       logic_rst,
  input  logic [7:0] net_tmac_data_in,
  input  logic       net_tmac_valid_in,
  output logic       net_tmac_ready_out,
  input  logic       net_tmac_last_in,
  output logic [7:0] gmii_txd_out,
  output logic       gmii_tx_en_out,
  output logic       gmii_tx_er_out,
  output logic       tx_busy_out,
  output logic       tx_underflow_out
);

  tx_state_t   state;
  logic [2:0]  sub_cnt;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [7:0]  crc_byte;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  assign net_tmac_ready_out = (state == DATA) || (state == DROP);
  assign tx_busy_out        = (state != IDLE);
  assign byte_cnt_inc       = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  // Pad cycles fold zero bytes into the CRC; only DATA feeds upstream bytes.
  assign crc_byte = (state == DATA) ? net_tmac_data_in : 8'h00;
  assign fcs      = ~crc;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data_in (crc_byte),
    .crc_out (crc_next)
  );

  always_comb begin
    case (sub_cnt[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  // Pins are registered alongside the state, so each byte appears one cycle after its state.
  always_ff @(posedge logic_clk) begin
    if (logic_rst) begin
      state            <= IDLE;
      sub_cnt          <= 3'd0;
      byte_cnt         <= 11'd0;
      crc              <= ETH_CRC_INIT;
      gmii_txd_out     <= 8'h00;
      gmii_tx_en_out   <= 1'b0;
      gmii_tx_er_out   <= 1'b0;
      tx_underflow_out <= 1'b0;
    end else begin
      gmii_txd_out     <= 8'h00;
      gmii_tx_en_out   <= 1'b0;
      gmii_tx_er_out   <= 1'b0;
      tx_underflow_out <= 1'b0;
      case (state)
        IDLE: begin
          if (net_tmac_valid_in) begin
            state          <= PREAMBLE;
            sub_cnt        <= 3'd0;
            gmii_txd_out   <= ETH_PREAMBLE;
            gmii_tx_en_out <= 1'b1;
          end
        end
        PREAMBLE: begin
          gmii_txd_out   <= ETH_PREAMBLE;
          gmii_tx_en_out <= 1'b1;
          sub_cnt        <= sub_cnt + 3'd1;
          if (sub_cnt == 3'd5) state <= SFD;
        end
        SFD: begin
          gmii_txd_out   <= ETH_SFD;
          gmii_tx_en_out <= 1'b1;
          crc            <= ETH_CRC_INIT;
          byte_cnt       <= 11'd0;
          state          <= DATA;
        end
        DATA: begin
          gmii_tx_en_out <= 1'b1;
          if (net_tmac_valid_in) begin
            gmii_txd_out <= net_tmac_data_in;
            crc          <= crc_next;
            byte_cnt     <= byte_cnt_inc;
            if (net_tmac_last_in) begin
`ifdef ETH_TX_PAD_EN
              if (int'(byte_cnt) + 1 < MIN_FRAME_BYTES) begin
                state <= PAD;
              end else begin
                state   <= FCS;
                sub_cnt <= 3'd0;
              end
`else
              state   <= FCS;
              sub_cnt <= 3'd0;
`endif
            end
          end else begin
            gmii_tx_er_out   <= 1'b1;
            tx_underflow_out <= 1'b1;
            state            <= DROP;
          end
        end
`ifdef ETH_TX_PAD_EN
        PAD: begin
          gmii_tx_en_out <= 1'b1;
          crc            <= crc_next;
          byte_cnt       <= byte_cnt_inc;
          if (int'(byte_cnt) + 1 >= MIN_FRAME_BYTES) begin
            state   <= FCS;
            sub_cnt <= 3'd0;
          end
        end
`endif
        FCS: begin
          gmii_txd_out   <= fcs_byte;
          gmii_tx_en_out <= 1'b1;
          sub_cnt        <= sub_cnt + 3'd1;
          if (sub_cnt == 3'd3) begin
            state    <= IFG;
            byte_cnt <= 11'd0;
          end
        end
        DROP: begin
          if (net_tmac_valid_in && net_tmac_last_in) begin
            state    <= IFG;
            byte_cnt <= 11'd0;
          end
        end
        IFG: begin
          if (int'(byte_cnt) >= IFG_BYTES - 1) state <= IDLE;
          else                                 byte_cnt <= byte_cnt_inc;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
